// File: rtl/toysram_pkg.sv
// toysram_pkg: shared widths, predecoded line bundle and write FSM states for the 64x24 2r1w toysram driver
package toysram_pkg;
   localparam int ADDR_W = 6;
   localparam int DAT_W = 24;
   typedef struct packed {
      logic c_na0;
      logic c_a0;
      logic na1_na2;
      logic na1_a2;
      logic a1_na2;
      logic a1_a2;
      logic na3;
      logic a3;
      logic na4_na5;
      logic na4_a5;
      logic a4_na5;
      logic a4_a5;
   } predec_t;
   typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wr_state_t;
endpackage

// File: rtl/toysram_predec.sv
// toysram_predec: binary address plus enable to the array's one-hot predecoded lines
module toysram_predec
   import toysram_pkg::*;
(
   input  logic              en,
   input  logic [0:ADDR_W-1] addr,
   output predec_t           lines
);
   assign lines = {en & ~addr[0], en & addr[0],
                   en & ~addr[1] & ~addr[2], en & ~addr[1] & addr[2],
                   en & addr[1] & ~addr[2], en & addr[1] & addr[2],
                   en & ~addr[3], en & addr[3],
                   en & ~addr[4] & ~addr[5], en & ~addr[4] & addr[5],
                   en & addr[4] & ~addr[5], en & addr[4] & addr[5]};
endmodule

// File: rtl/toysram_64x24_2r1w_drv.sv
// toysram_64x24_2r1w_drv: valid/ready to predecoded-line driver for the 64x24 2r1w toysram array
// TOYSRAM_WR_BYPASS_EN: conflicting reads are not stalled and get the in-flight write data instead
module toysram_64x24_2r1w_drv
   import toysram_pkg::*;
#(
   parameter int WR_PULSE_CYC = 1,
   parameter int WR_HOLD_CYC = 1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              rd0_req_val,
   output logic              rd0_req_rdy,
   input  logic [0:ADDR_W-1] rd0_req_addr,
   output logic              rd0_rsp_val,
   output logic [0:DAT_W-1]  rd0_rsp_dat,
   input  logic              rd1_req_val,
   output logic              rd1_req_rdy,
   input  logic [0:ADDR_W-1] rd1_req_addr,
   output logic              rd1_rsp_val,
   output logic [0:DAT_W-1]  rd1_rsp_dat,
   input  logic              wr_req_val,
   output logic              wr_req_rdy,
   input  logic [0:ADDR_W-1] wr_req_addr,
   input  logic [0:DAT_W-1]  wr_req_dat,
   output logic              rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
   output logic              rd0_na3, rd0_a3, rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5,
   output logic              rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
   output logic              rd1_na3, rd1_a3, rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5,
   output logic              wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
   output logic              wr0_na3, wr0_a3, wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5,
   input  logic [0:DAT_W-1]  rd0_dat,
   input  logic [0:DAT_W-1]  rd1_dat,
   output logic [0:DAT_W-1]  wr0_dat
);
   localparam logic [3:0] PULSE_LAST = 4'(WR_PULSE_CYC - 1);
   localparam logic [3:0] HOLD_LAST = 4'(WR_HOLD_CYC - 1);
   wr_state_t st, nxt;
   logic [3:0] cnt, cnt_nxt;
   logic act, busy, wr_acc, last;
   logic [0:ADDR_W-1] wa, w_addr;
   predec_t w_d, w_q;
   predec_t [1:0] r_d, r_q;
   logic [1:0][0:ADDR_W-1] rd_addr;
   logic [1:0][0:DAT_W-1] rd_dat, rsp_dat;
   logic [1:0] rd_val, rd_rdy, rd_acc, conf, byp, v1, b1, rsp_val;
   assign rd_val = {rd1_req_val, rd0_req_val};
   assign rd_addr = {rd1_req_addr, rd0_req_addr};
   assign rd_dat = {rd1_dat, rd0_dat};
   assign {rd1_req_rdy, rd0_req_rdy} = rd_rdy;
   assign {rd1_rsp_val, rd0_rsp_val} = rsp_val;
   assign {rd1_rsp_dat, rd0_rsp_dat} = rsp_dat;
   assign {rd0_c_na0, rd0_c_a0, rd0_na1_na2, rd0_na1_a2, rd0_a1_na2, rd0_a1_a2,
           rd0_na3, rd0_a3, rd0_na4_na5, rd0_na4_a5, rd0_a4_na5, rd0_a4_a5} = r_q[0];
   assign {rd1_c_na0, rd1_c_a0, rd1_na1_na2, rd1_na1_a2, rd1_a1_na2, rd1_a1_a2,
           rd1_na3, rd1_a3, rd1_na4_na5, rd1_na4_a5, rd1_a4_na5, rd1_a4_a5} = r_q[1];
   assign {wr0_c_na0, wr0_c_a0, wr0_na1_na2, wr0_na1_a2, wr0_a1_na2, wr0_a1_a2,
           wr0_na3, wr0_a3, wr0_na4_na5, wr0_na4_a5, wr0_a4_na5, wr0_a4_a5} = w_q;
   assign busy = st != IDLE;
   assign wr_req_rdy = act & ~busy;
   assign wr_acc = wr_req_val & wr_req_rdy;
   assign w_addr = wr_acc ? wr_req_addr : wa;
   always_comb begin
      last = (st == STROBE) ? cnt == PULSE_LAST : cnt == HOLD_LAST;
      nxt = st == IDLE ? (wr_acc ? SETUP : IDLE)
          : st == SETUP ? STROBE
          : st == STROBE ? (last ? HOLD : STROBE)
          : (last ? IDLE : HOLD);
      cnt_nxt = (busy && nxt == st) ? cnt + 4'd1 : 4'd0;
   end
   assign conf = busy ? {rd_addr[1] == wa, rd_addr[0] == wa} : 2'b00;
`ifdef TOYSRAM_WR_BYPASS_EN
   assign rd_rdy = {2{act}};
`else
   assign rd_rdy = {2{act}} & ~conf;
`endif
   assign rd_acc = rd_val & rd_rdy;
   assign byp = rd_acc & conf;
   toysram_predec u_wr (.en(nxt != IDLE), .addr(w_addr), .lines(w_d));
   for (genvar p = 0; p < 2; p++) begin : g_rd
      toysram_predec u_rd (.en(rd_acc[p] & ~byp[p]), .addr(rd_addr[p]), .lines(r_d[p]));
   end
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         act <= 1'b0;
         st <= IDLE;
         cnt <= '0;
         wa <= '0;
         wr0_dat <= '0;
         w_q <= '0;
         r_q <= '0;
         v1 <= '0;
         b1 <= '0;
         rsp_val <= '0;
         rsp_dat <= '0;
      end else begin
         act <= 1'b1;
         st <= nxt;
         cnt <= cnt_nxt;
         wa <= w_addr;
         if (wr_acc) wr0_dat <= wr_req_dat;
         // address lines span SETUP..HOLD; the a0 pair doubles as the write strobe
         w_q <= w_d;
         w_q.c_na0 <= w_d.c_na0 & (nxt == STROBE);
         w_q.c_a0 <= w_d.c_a0 & (nxt == STROBE);
         r_q <= r_d;
         v1 <= rd_acc;
         b1 <= byp;
         rsp_val <= v1;
         for (int i = 0; i < 2; i++)
            if (v1[i]) rsp_dat[i] <= b1[i] ? wr0_dat : rd_dat[i];
      end
   end
endmodule
